// File: rtl/br_resolve_ctrl.sv
// Branch-resolve sequencer: mispredict flush/redirect FSM plus buffered BTB write queue (BR_RESOLVE_COALESCE_EN merges same-addr updates).
// Latency: flush N+1..N+FLUSH_CYCLES, redirect N+FLUSH_CYCLES+1; a queued BTB update reaches the port no earlier than N+1.
// Backpressure: fetch_btb_rd defers queue drains; an update arriving at a full, non-draining queue is dropped (wq_drop).
module br_resolve_ctrl #(
    parameter int BTB_ADDR_BITS = 8,
    parameter int WQ_DEPTH      = 4,
    parameter int FLUSH_CYCLES  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     br_valid,
    input  logic                     br_pc_select,
    input  logic [31:0]              br_pc_branch,
    input  logic                     br_btb_web,
    input  logic [BTB_ADDR_BITS-1:0] br_btb_addr,
    input  logic [31:0]              br_btb_din,
    input  logic                     fetch_btb_rd,
    output logic                     btb_web,
    output logic [BTB_ADDR_BITS-1:0] btb_addr,
    output logic [31:0]              btb_din,
    output logic                     flush,
    output logic                     fetch_stall,
    output logic                     redirect_valid,
    output logic [31:0]              redirect_pc,
    output logic                     wq_full,
    output logic                     wq_drop,
    output logic [31:0]              redirect_count
);
    localparam int PTR_W = $clog2(WQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] WQ_FULL_CNT = CNT_W'(WQ_DEPTH);
    localparam logic [FC_W-1:0]  FC_LOAD     = FC_W'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_REDIRECT} state_t;

    state_t            state_q, state_d;
    logic [FC_W-1:0]   fc_q;
    logic [31:0]       target_q;
    logic              mispredict;

    // Results arriving outside IDLE are younger than the mispredict and are squashed.
    assign mispredict = (state_q == S_IDLE) && br_valid && br_pc_select;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        flush          = 1'b0;
        fetch_stall    = 1'b0;
        redirect_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mispredict) state_d = S_FLUSH;
            end
            S_FLUSH: begin
                flush       = 1'b1;
                fetch_stall = 1'b1;
                if (fc_q == '0) state_d = S_REDIRECT;
            end
            S_REDIRECT: begin
                redirect_valid = 1'b1;
                fetch_stall    = 1'b1;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fc_q           <= '0;
            target_q       <= '0;
            redirect_count <= '0;
        end else begin
            if (mispredict) begin
                fc_q     <= FC_LOAD;
                target_q <= br_pc_branch;
            end else if (state_q == S_FLUSH && fc_q != '0) begin
                fc_q <= fc_q - FC_W'(1);
            end
            if (state_q == S_REDIRECT) redirect_count <= redirect_count + 32'd1;
        end
    end

    assign redirect_pc = target_q;

    logic [BTB_ADDR_BITS-1:0] addr_mem [WQ_DEPTH];
    logic [31:0]              data_mem [WQ_DEPTH];
    logic [PTR_W-1:0]         rd_ptr, wr_ptr;
    logic [CNT_W-1:0]         wq_cnt;
    logic                     wq_empty, enq_req, deq, coal_hit, push, drop;

    assign wq_empty = (wq_cnt == '0);
    assign wq_full  = (wq_cnt == WQ_FULL_CNT);
    assign enq_req  = (state_q == S_IDLE) && br_valid && !br_btb_web;
    assign deq      = !wq_empty && !fetch_btb_rd;
    assign push     = enq_req && !coal_hit && (!wq_full || deq);
    assign drop     = enq_req && !coal_hit && wq_full && !deq;

`ifdef BR_RESOLVE_COALESCE_EN
    logic [PTR_W-1:0] coal_idx;

    // A head entry leaving this cycle is not a merge target; the update then appends instead.
    always_comb begin
        coal_hit = 1'b0;
        coal_idx = '0;
        for (int i = 0; i < WQ_DEPTH; i++) begin
            if (enq_req && (CNT_W'(i) < wq_cnt) && !((i == 0) && deq) &&
                (addr_mem[rd_ptr + PTR_W'(i)] == br_btb_addr)) begin
                coal_hit = 1'b1;
                coal_idx = rd_ptr + PTR_W'(i);
            end
        end
    end
`else
    assign coal_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= br_btb_addr;
            data_mem[wr_ptr] <= br_btb_din;
        end
`ifdef BR_RESOLVE_COALESCE_EN
        else if (coal_hit) begin
            data_mem[coal_idx] <= br_btb_din;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            wq_cnt  <= '0;
            wq_drop <= 1'b0;
        end else begin
            wq_drop <= drop;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (deq)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, deq})
                2'b10:   wq_cnt <= wq_cnt + CNT_W'(1);
                2'b01:   wq_cnt <= wq_cnt - CNT_W'(1);
                default: wq_cnt <= wq_cnt;
            endcase
        end
    end

    assign btb_web  = !deq;
    assign btb_addr = wq_empty ? '0 : addr_mem[rd_ptr];
    assign btb_din  = wq_empty ? '0 : data_mem[rd_ptr];

endmodule

// File: tb/tb_br_resolve_ctrl.sv
// Bench for br_resolve_ctrl: directed vector table, corner-case sequences, then random traffic against a queue/timeline model.
`timescale 1ns/1ps
module tb_br_resolve_ctrl;
    localparam int AW = 8;
    localparam int D  = 4;
    localparam int F  = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          br_valid, br_pc_select, br_btb_web, fetch_btb_rd;
    logic [31:0]   br_pc_branch, br_btb_din;
    logic [AW-1:0] br_btb_addr;
    logic          btb_web, flush, fetch_stall, redirect_valid, wq_full, wq_drop;
    logic [AW-1:0] btb_addr;
    logic [31:0]   btb_din, redirect_pc, redirect_count;

    always #5 clk = ~clk;

    br_resolve_ctrl #(.BTB_ADDR_BITS(AW), .WQ_DEPTH(D), .FLUSH_CYCLES(F)) dut (
        .clk(clk), .rst_n(rst_n),
        .br_valid(br_valid), .br_pc_select(br_pc_select), .br_pc_branch(br_pc_branch),
        .br_btb_web(br_btb_web), .br_btb_addr(br_btb_addr), .br_btb_din(br_btb_din),
        .fetch_btb_rd(fetch_btb_rd),
        .btb_web(btb_web), .btb_addr(btb_addr), .btb_din(btb_din),
        .flush(flush), .fetch_stall(fetch_stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .wq_full(wq_full), .wq_drop(wq_drop), .redirect_count(redirect_count)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } ent_t;

    typedef struct {
        logic bv; logic sel; logic [31:0] pc; logic web; logic [AW-1:0] addr; logic [31:0] din; logic frd;
        logic e_flush; logic e_stall; logic e_rv; logic [31:0] e_rpc;
        logic e_web; logic [AW-1:0] e_addr; logic [31:0] e_din; logic e_full; logic e_drop; logic [31:0] e_rc;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: pending BTB updates as a queue, redirect timing from the mispredict cycle number.
    ent_t        mq[$];
    int          cyc = 0;
    int          mp_cyc;
    logic [31:0] m_target;
    logic [31:0] m_rc;
    logic        m_drop;

    logic          obs_web, obs_drop, obs_full;
    logic [AW-1:0] obs_addr;
    logic [31:0]   obs_din;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic bv, input logic sel, input logic [31:0] pc, input logic web,
                         input logic [AW-1:0] addr, input logic [31:0] din, input logic frd);
        br_valid = bv; br_pc_select = sel; br_pc_branch = pc;
        br_btb_web = web; br_btb_addr = addr; br_btb_din = din; fetch_btb_rd = frd;
    endtask

    task automatic drive_idle(input logic frd);
        drive(1'b0, 1'b0, 32'h0, 1'b1, '0, 32'h0, frd);
    endtask

    function automatic bit m_busy();
        return (cyc >= mp_cyc + 1) && (cyc <= mp_cyc + F + 1);
    endfunction

    task automatic model_reset();
        mq.delete();
        mp_cyc   = -100;
        m_target = '0;
        m_rc     = '0;
        m_drop   = 1'b0;
    endtask

    task automatic check_reset_values();
        chk("rst btb_web", 32'(btb_web), 1);
        chk("rst btb_addr", 32'(btb_addr), 0);
        chk("rst btb_din", btb_din, 0);
        chk("rst flush", 32'(flush), 0);
        chk("rst fetch_stall", 32'(fetch_stall), 0);
        chk("rst redirect_valid", 32'(redirect_valid), 0);
        chk("rst redirect_pc", redirect_pc, 0);
        chk("rst wq_full", 32'(wq_full), 0);
        chk("rst wq_drop", 32'(wq_drop), 0);
        chk("rst redirect_count", redirect_count, 0);
    endtask

    task automatic check_model();
        bit          busy;
        bit          redir;
        logic [AW-1:0] ea;
        logic [31:0] ed;
        busy  = m_busy();
        redir = (cyc == mp_cyc + F + 1);
        ea = '0;
        ed = '0;
        if (mq.size() != 0) begin
            ea = mq[0].addr;
            ed = mq[0].data;
        end
        chk("m flush", 32'(flush), 32'(busy && (cyc <= mp_cyc + F)));
        chk("m fetch_stall", 32'(fetch_stall), 32'(busy));
        chk("m redirect_valid", 32'(redirect_valid), 32'(redir));
        if (redir) chk("m redirect_pc", redirect_pc, m_target);
        chk("m redirect_count", redirect_count, m_rc);
        chk("m wq_full", 32'(wq_full), 32'(mq.size() == D));
        chk("m wq_drop", 32'(wq_drop), 32'(m_drop));
        chk("m btb_web", 32'(btb_web), 32'(!(mq.size() != 0 && !fetch_btb_rd)));
        chk("m btb_addr", 32'(btb_addr), 32'(ea));
        chk("m btb_din", btb_din, ed);
    endtask

    task automatic model_update();
        bit   busy, deq, enq, merged;
        int   sz;
        ent_t e;
        busy   = m_busy();
        deq    = (mq.size() != 0) && !fetch_btb_rd;
        enq    = !busy && br_valid && !br_btb_web;
        merged = 0;
        if (cyc == mp_cyc + F + 1) m_rc = m_rc + 1;
        if (!busy && br_valid && br_pc_select) begin
            mp_cyc   = cyc;
            m_target = br_pc_branch;
        end
`ifdef BR_RESOLVE_COALESCE_EN
        if (enq) begin
            for (int j = (deq ? 1 : 0); j < mq.size(); j++) begin
                if (mq[j].addr == br_btb_addr) begin
                    e = mq[j];
                    e.data = br_btb_din;
                    mq[j] = e;
                    merged = 1;
                end
            end
        end
`endif
        sz = mq.size();
        m_drop = 1'b0;
        if (deq) void'(mq.pop_front());
        if (enq && !merged) begin
            if (sz < D || deq) begin
                e.addr = br_btb_addr;
                e.data = br_btb_din;
                mq.push_back(e);
            end else begin
                m_drop = 1'b1;
            end
        end
        cyc++;
    endtask

    task automatic step();
        @(negedge clk);
        check_model();
        obs_web  = btb_web;
        obs_addr = btb_addr;
        obs_din  = btb_din;
        obs_drop = wq_drop;
        obs_full = wq_full;
        model_update();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic bv, input logic sel, input logic [31:0] pc, input logic web,
                                input logic [AW-1:0] addr, input logic [31:0] din, input logic frd,
                                input logic fl, input logic st, input logic rv, input logic [31:0] rpc,
                                input logic ew, input logic [AW-1:0] ea, input logic [31:0] ed,
                                input logic full, input logic drop, input logic [31:0] rc);
        vec_t v;
        v.bv = bv; v.sel = sel; v.pc = pc; v.web = web; v.addr = addr; v.din = din; v.frd = frd;
        v.e_flush = fl; v.e_stall = st; v.e_rv = rv; v.e_rpc = rpc;
        v.e_web = ew; v.e_addr = ea; v.e_din = ed; v.e_full = full; v.e_drop = drop; v.e_rc = rc;
        return v;
    endfunction

    vec_t          tbl[10];
    int            drops;
    int            nw;
    logic [AW-1:0] got_addr[8];
    logic [31:0]   got_din[8];

    task automatic drain_collect(input int ncyc);
        nw = 0;
        for (int k = 0; k < 8; k++) begin
            got_addr[k] = 8'hFF;
            got_din[k]  = 32'hFFFF_FFFF;
        end
        for (int k = 0; k < ncyc; k++) begin
            drive_idle(1'b0);
            step();
            if (!obs_web) begin
                if (nw < 8) begin
                    got_addr[nw] = obs_addr;
                    got_din[nw]  = obs_din;
                end
                nw++;
            end
        end
    endtask

    initial begin
        //          bv sel pc            web addr   din           frd | fl st rv rpc           web addr   din           full drop rc
        tbl[0] = mk(0, 0, 32'h0,         1, 8'h00, 32'h0,         0,   0, 0, 0, 32'h0,        1, 8'h00, 32'h0,         0, 0, 0);
        tbl[1] = mk(1, 1, 32'h0000_1040, 1, 8'h00, 32'h0,         0,   0, 0, 0, 32'h0,        1, 8'h00, 32'h0,         0, 0, 0);
        tbl[2] = mk(1, 1, 32'h0000_2000, 0, 8'h05, 32'h0000_DEAD, 0,   1, 1, 0, 32'h0,        1, 8'h00, 32'h0,         0, 0, 0);
        tbl[3] = mk(0, 0, 32'h0,         1, 8'h00, 32'h0,         0,   1, 1, 0, 32'h0,        1, 8'h00, 32'h0,         0, 0, 0);
        tbl[4] = mk(0, 0, 32'h0,         1, 8'h00, 32'h0,         0,   0, 1, 1, 32'h0000_1040, 1, 8'h00, 32'h0,        0, 0, 0);
        tbl[5] = mk(1, 0, 32'h0,         0, 8'h12, 32'h8000_0100, 1,   0, 0, 0, 32'h0,        1, 8'h00, 32'h0,         0, 0, 1);
        tbl[6] = mk(0, 0, 32'h0,         1, 8'h00, 32'h0,         1,   0, 0, 0, 32'h0,        1, 8'h12, 32'h8000_0100, 0, 0, 1);
        tbl[7] = mk(0, 0, 32'h0,         1, 8'h00, 32'h0,         1,   0, 0, 0, 32'h0,        1, 8'h12, 32'h8000_0100, 0, 0, 1);
        tbl[8] = mk(0, 0, 32'h0,         1, 8'h00, 32'h0,         0,   0, 0, 0, 32'h0,        0, 8'h12, 32'h8000_0100, 0, 0, 1);
        tbl[9] = mk(0, 0, 32'h0,         1, 8'h00, 32'h0,         0,   0, 0, 0, 32'h0,        1, 8'h00, 32'h0,         0, 0, 1);

        rst_n = 1'b0;
        drive_idle(1'b0);
        model_reset();
        #12;
        check_reset_values();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Mispredict, squashed younger result, fetch priority on the BTB port.
        for (int r = 0; r < 10; r++) begin
            drive(tbl[r].bv, tbl[r].sel, tbl[r].pc, tbl[r].web, tbl[r].addr, tbl[r].din, tbl[r].frd);
            @(negedge clk);
            chk($sformatf("row%0d flush", r), 32'(flush), 32'(tbl[r].e_flush));
            chk($sformatf("row%0d fetch_stall", r), 32'(fetch_stall), 32'(tbl[r].e_stall));
            chk($sformatf("row%0d redirect_valid", r), 32'(redirect_valid), 32'(tbl[r].e_rv));
            if (tbl[r].e_rv) chk($sformatf("row%0d redirect_pc", r), redirect_pc, tbl[r].e_rpc);
            chk($sformatf("row%0d btb_web", r), 32'(btb_web), 32'(tbl[r].e_web));
            chk($sformatf("row%0d btb_addr", r), 32'(btb_addr), 32'(tbl[r].e_addr));
            chk($sformatf("row%0d btb_din", r), btb_din, tbl[r].e_din);
            chk($sformatf("row%0d wq_full", r), 32'(wq_full), 32'(tbl[r].e_full));
            chk($sformatf("row%0d wq_drop", r), 32'(wq_drop), 32'(tbl[r].e_drop));
            chk($sformatf("row%0d redirect_count", r), redirect_count, tbl[r].e_rc);
            model_update();
            @(posedge clk);
            #1;
        end

        // Overflow with fetch holding the port.
        drops = 0;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b0, 32'h0, 1'b0, AW'(8'h20 + k), 32'h100 + k, 1'b1);
            step();
            drops += int'(obs_drop);
            if (k == 3) chk("ovf not full before 4th", 32'(obs_full), 0);
            if (k == 4) chk("ovf full after 4th", 32'(obs_full), 1);
        end
        for (int k = 0; k < 2; k++) begin
            drive_idle(1'b1);
            step();
            drops += int'(obs_drop);
        end
        chk("ovf drop pulses", drops, 1);
        drain_collect(8);
        chk("ovf write count", nw, 4);
        for (int k = 0; k < 4; k++) chk($sformatf("ovf write%0d addr", k), 32'(got_addr[k]), 32'h20 + k);

        // Full queue with enqueue and dequeue in the same cycle.
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 32'h0, 1'b0, AW'(8'h30 + k), 32'h200 + k, 1'b1);
            step();
        end
        drive(1'b1, 1'b0, 32'h0, 1'b0, 8'h34, 32'h204, 1'b0);
        step();
        chk("fulldeq full", 32'(obs_full), 1);
        chk("fulldeq write", 32'(obs_web), 0);
        drive_idle(1'b1);
        step();
        chk("fulldeq no drop", 32'(obs_drop), 0);
        chk("fulldeq still full", 32'(obs_full), 1);
        drain_collect(8);
        chk("fulldeq write count", nw, 4);
        for (int k = 0; k < 4; k++) chk($sformatf("fulldeq write%0d addr", k), 32'(got_addr[k]), 32'h31 + k);

`ifdef BR_RESOLVE_COALESCE_EN
        drive(1'b1, 1'b0, 32'h0, 1'b0, 8'h07, 32'hA, 1'b1);
        step();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 8'h07, 32'hB, 1'b1);
        step();
        drive_idle(1'b1);
        step();
        drain_collect(6);
        chk("coal write count", nw, 1);
        chk("coal addr", 32'(got_addr[0]), 32'h07);
        chk("coal data", got_din[0], 32'hB);
`endif

        // Reset in the middle of a flush with a queued write.
        drive(1'b1, 1'b1, 32'h0000_3000, 1'b0, 8'h44, 32'h55, 1'b1);
        step();
        drive_idle(1'b1);
        step();
        rst_n = 1'b0;
        #2;
        check_reset_values();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 5; k++) begin
            drive_idle(1'b0);
            step();
        end

        // Random traffic against the model.
        for (int i = 0; i < 800; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0), $urandom,
                  1'($urandom_range(0, 1)), AW'($urandom_range(0, 5)), $urandom,
                  1'($urandom_range(0, 2) == 0));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
